// File: rtl/vga_timing_gen.sv
// VGA/DVI raster timing generator: free-running h/v counters, a registered fetch stage and a
// configurable-depth display pipeline so fetched pixel data lines up with sync/blank.
module vga_timing_gen #(
  parameter int unsigned p_h_active      = 640,
  parameter int unsigned p_h_fp          = 16,
  parameter int unsigned p_h_sync        = 96,
  parameter int unsigned p_h_bp          = 48,
  parameter int unsigned p_v_active      = 480,
  parameter int unsigned p_v_fp          = 10,
  parameter int unsigned p_v_sync        = 2,
  parameter int unsigned p_v_bp          = 33,
  parameter logic        p_h_sync_pol    = 1'b0,
  parameter logic        p_v_sync_pol    = 1'b0,
  parameter int unsigned p_fetch_latency = 2
) (
  input  logic        i_clk_pixel,
  input  logic        i_rst,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_blank,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_frame_start,
  output logic        o_line_start,
  output logic        o_fetch_valid,
  output logic [11:0] o_fetch_x,
  output logic [11:0] o_fetch_y
);

  localparam int unsigned HTotal = p_h_active + p_h_fp + p_h_sync + p_h_bp;
  localparam int unsigned VTotal = p_v_active + p_v_fp + p_v_sync + p_v_bp;

  if (HTotal > 4096 || VTotal > 4096) begin : g_bad_total
    $error("vga_timing_gen: H or V total exceeds 4096");
  end
  if (p_fetch_latency > 15) begin : g_bad_latency
    $error("vga_timing_gen: p_fetch_latency exceeds 15");
  end

  localparam logic [12:0] HActive    = 13'(p_h_active);
  localparam logic [12:0] HSyncStart = 13'(p_h_active + p_h_fp);
  localparam logic [12:0] HSyncEnd   = 13'(p_h_active + p_h_fp + p_h_sync);
  localparam logic [12:0] VActive    = 13'(p_v_active);
  localparam logic [12:0] VSyncStart = 13'(p_v_active + p_v_fp);
  localparam logic [12:0] VSyncEnd   = 13'(p_v_active + p_v_fp + p_v_sync);
  localparam logic [11:0] HLast      = 12'(HTotal - 1);
  localparam logic [11:0] VLast      = 12'(VTotal - 1);

  // Sync fields hold "asserted", polarity is applied only at the output pins.
  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic [11:0] x;
    logic [11:0] y;
    logic        frame_start;
    logic        line_start;
  } bundle_t;

  localparam bundle_t IdleBundle = '{
    hsync: 1'b0, vsync: 1'b0, blank: 1'b1, x: 12'd0, y: 12'd0,
    frame_start: 1'b0, line_start: 1'b0
  };

  logic [11:0] hc_q, hc_d, vc_q, vc_d;
  logic [12:0] hc_w, vc_w;
  bundle_t     cur_b, fetch_q, disp_b;

  assign hc_w = {1'b0, hc_q};
  assign vc_w = {1'b0, vc_q};

  always_comb begin
    hc_d = hc_q + 12'd1;
    vc_d = vc_q;
    if (hc_q == HLast) begin
      hc_d = 12'd0;
      vc_d = (vc_q == VLast) ? 12'd0 : vc_q + 12'd1;
    end
  end

  always_comb begin
    cur_b             = IdleBundle;
    cur_b.hsync       = (hc_w >= HSyncStart) && (hc_w < HSyncEnd);
    cur_b.vsync       = (vc_w >= VSyncStart) && (vc_w < VSyncEnd);
    cur_b.blank       = (hc_w >= HActive) || (vc_w >= VActive);
    cur_b.x           = hc_q;
    cur_b.y           = vc_q;
    cur_b.frame_start = (hc_q == 12'd0) && (vc_q == 12'd0);
    cur_b.line_start  = (hc_q == 12'd0) && (vc_w < VActive);
  end

  always_ff @(posedge i_clk_pixel) begin
    if (!i_rst) begin
      hc_q    <= 12'd0;
      vc_q    <= 12'd0;
      fetch_q <= IdleBundle;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      fetch_q <= cur_b;
    end
  end

  if (p_fetch_latency == 0) begin : g_no_pipe
    assign disp_b = fetch_q;
  end else begin : g_pipe
    bundle_t pipe_q [p_fetch_latency];

    always_ff @(posedge i_clk_pixel) begin
      if (!i_rst) begin
        for (int unsigned i = 0; i < p_fetch_latency; i++) begin
          pipe_q[i] <= IdleBundle;
        end
      end else begin
        pipe_q[0] <= fetch_q;
        for (int unsigned i = 1; i < p_fetch_latency; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign disp_b = pipe_q[p_fetch_latency-1];
  end

  assign o_fetch_valid = ~fetch_q.blank;
  assign o_fetch_x     = fetch_q.x;
  assign o_fetch_y     = fetch_q.y;

  assign o_hsync       = disp_b.hsync ? p_h_sync_pol : ~p_h_sync_pol;
  assign o_vsync       = disp_b.vsync ? p_v_sync_pol : ~p_v_sync_pol;
  assign o_blank       = disp_b.blank;
  assign o_x           = disp_b.x;
  assign o_y           = disp_b.y;
  assign o_frame_start = disp_b.frame_start;
  assign o_line_start  = disp_b.line_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance plus small-raster instances at several
// latencies/polarities, all checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_def, rst_s;
  int   total = 0;
  int   bad = 0;
  int   k_def = -2;
  int   k_s = -2;
  int   cyc = 0;

  logic        hs [6];
  logic        vs [6];
  logic        bl [6];
  logic        fs [6];
  logic        ls [6];
  logic        fv [6];
  logic [11:0] x  [6];
  logic [11:0] y  [6];
  logic [11:0] fx [6];
  logic [11:0] fy [6];

  int lat_a [6] = '{2, 2, 0, 1, 5, 2};

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .i_clk_pixel(clk), .i_rst(rst_def), .o_hsync(hs[0]), .o_vsync(vs[0]), .o_blank(bl[0]),
    .o_x(x[0]), .o_y(y[0]), .o_frame_start(fs[0]), .o_line_start(ls[0]),
    .o_fetch_valid(fv[0]), .o_fetch_x(fx[0]), .o_fetch_y(fy[0])
  );

  for (genvar g = 1; g < 6; g++) begin : g_small
    vga_timing_gen #(
      .p_h_active(16), .p_h_fp(2), .p_h_sync(3), .p_h_bp(4),
      .p_v_active(6), .p_v_fp(1), .p_v_sync(2), .p_v_bp(3),
      .p_h_sync_pol(g == 5 ? 1'b1 : 1'b0), .p_v_sync_pol(g == 5 ? 1'b1 : 1'b0),
      .p_fetch_latency(g == 2 ? 0 : g == 3 ? 1 : g == 4 ? 5 : 2)
    ) u_dut (
      .i_clk_pixel(clk), .i_rst(rst_s), .o_hsync(hs[g]), .o_vsync(vs[g]), .o_blank(bl[g]),
      .o_x(x[g]), .o_y(y[g]), .o_frame_start(fs[g]), .o_line_start(ls[g]),
      .o_fetch_valid(fv[g]), .o_fetch_x(fx[g]), .o_fetch_y(fy[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // k = number of edges since release (0 at E0), -1 while in reset.
  // Output: {hsync, vsync, blank, x, y, frame_start, line_start, fetch_valid, fetch_x, fetch_y}
  function automatic logic [53:0] model(input int k, lat, ha, hfp, hsw, hbp, va, vfp, vsw,
                                        vbp, input bit hpol, vpol);
    int ht, vt, p, j, px, py;
    logic hsa, vsa, blk, fsp, lsp, fval;
    logic [11:0] dx, dy, fxx, fyy;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    fval = 1'b0; fxx = 12'd0; fyy = 12'd0;
    if (k >= 0) begin
      p    = k % (ht * vt);
      fxx  = 12'(p % ht);
      fyy  = 12'(p / ht);
      fval = (p % ht < ha) && (p / ht < va);
    end
    hsa = 1'b0; vsa = 1'b0; blk = 1'b1; dx = 12'd0; dy = 12'd0; fsp = 1'b0; lsp = 1'b0;
    j = k - lat;
    if (j >= 0) begin
      p   = j % (ht * vt);
      px  = p % ht;
      py  = p / ht;
      hsa = (px >= ha + hfp) && (px < ha + hfp + hsw);
      vsa = (py >= va + vfp) && (py < va + vfp + vsw);
      blk = (px >= ha) || (py >= va);
      dx  = 12'(px);
      dy  = 12'(py);
      fsp = (p == 0);
      lsp = (px == 0) && (py < va);
    end
    return {hsa ? hpol : ~hpol, vsa ? vpol : ~vpol, blk, dx, dy, fsp, lsp, fval, fxx, fyy};
  endfunction

  function automatic logic [53:0] mdef(input int k);
    return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_def) k_def <= -1;
    else if (k_def != -2) k_def <= k_def + 1;
    if (!rst_s) k_s <= -1;
    else if (k_s != -2) k_s <= k_s + 1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin : cmp
      int k;
      logic [53:0] e, a;
      k = (i == 0) ? k_def : k_s;
      if (k != -2) begin
        if (i == 0) e = mdef(k);
        else e = model(k, lat_a[i], 16, 2, 3, 4, 6, 1, 2, 3, i == 5, i == 5);
        a = {hs[i], vs[i], bl[i], x[i], y[i], fs[i], ls[i], fv[i], fx[i], fy[i]};
        check($sformatf("model[%0d] k=%0d", i, k), 64'(a), 64'(e));
      end
    end
  end

  initial begin
    int n, c0, vfirst, hfirst, nls, nfs, nvs, nhs, nvp, nhp;
    rst_def = 1'b0;
    rst_s   = 1'b0;

    // Pin the model with hand-computed default-raster points.
    check("pin_e0", 64'(mdef(0)),
          64'({1'b1, 1'b1, 1'b1, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 12'd0, 12'd0}));
    check("pin_hsync", 64'(mdef(658)),
          64'({1'b0, 1'b1, 1'b1, 12'd656, 12'd0, 1'b0, 1'b0, 1'b0, 12'd658, 12'd0}));
    check("pin_vsync", 64'(mdef(490 * 800 + 2)),
          64'({1'b1, 1'b0, 1'b1, 12'd0, 12'd490, 1'b0, 1'b0, 1'b0, 12'd2, 12'd490}));
    check("pin_frame2", 64'(mdef(420002)),
          64'({1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 12'd2, 12'd0}));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_def = 1'b1;
    rst_s   = 1'b1;

    // Release: fetch (0,0) after E0, display (0,0) two cycles later.
    @(negedge clk);
    check("e0_fetch", 64'({fv[0], fx[0], fy[0]}), 64'({1'b1, 12'd0, 12'd0}));
    check("e0_blank", 64'(bl[0]), 64'd1);
    @(negedge clk);
    check("e1_idle", 64'({bl[0], fs[0]}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    check("e2_first_px", 64'({fs[0], ls[0], bl[0], x[0], y[0], hs[0], vs[0]}),
          64'({1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1}));
    c0 = cyc;

    // Line timing on the full-size raster.
    n = 0;
    while (!bl[0] && n < 2000) begin n++; @(negedge clk); end
    check("active_run_l0", 64'(n), 64'd640);
    n = 0;
    while (hs[0] && n < 2000) begin n++; @(negedge clk); end
    check("fp_len", 64'(n), 64'd16);
    n = 0;
    while (!hs[0] && n < 2000) begin n++; @(negedge clk); end
    check("hsync_len", 64'(n), 64'd96);
    n = 0;
    while (!ls[0] && n < 2000) begin n++; @(negedge clk); end
    check("line_period", 64'(cyc - c0), 64'd800);
    check("line1_pos", 64'({x[0], y[0]}), 64'({12'd0, 12'd1}));
    n = 0;
    while (!bl[0] && n < 2000) begin n++; @(negedge clk); end
    check("active_run_l1", 64'(n), 64'd640);

    // One full small frame (25 x 12 = 300 cycles).
    n = 0;
    while (!fs[1] && n < 400) begin n++; @(negedge clk); end
    check("frame_found", 64'(fs[1]), 64'd1);
    nls = 0; nfs = 0; nvs = 0; nhs = 0; nvp = 0; nhp = 0; vfirst = -1; hfirst = -1;
    for (int i = 0; i < 300; i++) begin
      if (ls[1]) nls++;
      if (fs[1]) nfs++;
      if (!vs[1]) begin nvs++; if (vfirst < 0) vfirst = i; end
      if (!hs[1]) nhs++;
      if (vs[5]) nvp++;
      if (hs[5]) begin nhp++; if (hfirst < 0) hfirst = i; end
      @(negedge clk);
    end
    check("frame_ls", 64'(nls), 64'd6);
    check("frame_fs", 64'(nfs), 64'd1);
    check("frame_vsync_len", 64'(nvs), 64'd50);
    check("frame_vsync_start", 64'(vfirst), 64'd175);
    check("frame_hsync_cnt", 64'(nhs), 64'd36);
    check("frame_period", 64'(fs[1]), 64'd1);
    check("pol_vsync_len", 64'(nvp), 64'd50);
    check("pol_hsync_cnt", 64'(nhp), 64'd36);
    check("pol_hsync_start", 64'(hfirst), 64'd18);

    // Mid-frame reset on the small raster at line 3, x = 10.
    n = 0;
    while (!(y[1] == 12'd3 && x[1] == 12'd10 && !bl[1]) && n < 400) begin
      n++; @(negedge clk);
    end
    check("reset_point", 64'({x[1], y[1]}), 64'({12'd10, 12'd3}));
    rst_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_idle", 64'({bl[1], fv[1], hs[1], vs[1], fs[1], ls[1]}),
            64'({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
      check("rst_pol_idle", 64'({hs[5], vs[5]}), 64'd0);
    end
    rst_s = 1'b1;
    @(negedge clk);
    check("re_e0_fetch", 64'({fv[1], fx[1], fy[1]}), 64'({1'b1, 12'd0, 12'd0}));
    @(negedge clk);
    check("re_e1_idle", 64'({bl[1], fs[1]}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    check("re_e2_first_px", 64'({fs[1], ls[1], bl[1], x[1], y[1], hs[1], vs[1]}),
          64'({1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1}));

    repeat (700) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
